bus_alu_ctrl: RTL and testbench

Control-and-arithmetic core of the pipelined 8-bit CPU. Combines three functions: the reset conditioner, the bus controller, and the 8-bit ALU adder. The reset conditioner synchronises the external reset. The bus controller decodes stage-2 main-bus assert/load codes and stage-1 LHS/RHS codes into per-register strobes. The adder is an 8-bit ALU adder with selectable carry and gated main-bus drive.

---
 rtl/bus_alu_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_bus_alu_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_alu_ctrl.sv
// -----------------------------------------------------------------------------
// bus_alu_ctrl
//
// This is the control and arithmetic core of the pipelined 8-bit CPU.
// It contains three functions:
//   * Reset conditioner. A two-flop synchroniser. It clears asynchronously and
//     releases synchronously.
//   * Bus controller. It decodes the stage-2 main-bus assert/load codes and
//     the stage-1 LHS/RHS assert codes into registered per-register strobes.
//   * ALU adder. It has a selectable carry term. It drives the main bus only
//     while the ALU is the selected source.
//
// Ports
//   clk                  system clock; all state changes on the rising edge
//   reset_in_n           external reset; asynchronous, active-low
//   reset_out_n          conditioned reset; active-low
//   main_assert[3:0]     main-bus source code
//   main_load[3:0]       main-bus destination code
//   lhs_assert[1:0]      LHS-bus source code
//   rhs_assert[1:0]      RHS-bus source code
//   reg_*_load/assert/LHS/RHS   registered register strobes
//   alu_assert           ALU drives the main bus
//   memBridge_load       memory bridge transfer enable
//   memBridge_direction  1 = memory to main bus, 0 = main bus to memory
//   carry_in             stored arithmetic carry flag
//   lhs, rhs[7:0]        ALU operands
//   carry_select[1:0]    carry source: 0 -> 0, 1 -> 1, 2 -> carry_in, 3 -> 0
//   result[7:0]          sum modulo 256 (combinational)
//   carry_out            carry out of bit 7 (combinational)
//   main_bus_out[7:0]    result while alu_assert is high, otherwise 0x00
//   main_bus_oe          drive enable for main_bus_out
// -----------------------------------------------------------------------------
module bus_alu_ctrl (
    input  logic       clk,
    input  logic       reset_in_n,
    output logic       reset_out_n,
    input  logic [3:0] main_assert,
    input  logic [3:0] main_load,
    input  logic [1:0] lhs_assert,
    input  logic [1:0] rhs_assert,
    output logic       reg_A_load,
    output logic       reg_A_assert,
    output logic       reg_A_LHS,
    output logic       reg_A_RHS,
    output logic       reg_B_load,
    output logic       reg_B_assert,
    output logic       reg_B_LHS,
    output logic       reg_B_RHS,
    output logic       reg_Const_load,
    output logic       reg_Const_assert,
    output logic       reg_TL_load,
    output logic       reg_TL_assert,
    output logic       reg_TH_load,
    output logic       reg_TH_assert,
    output logic       alu_assert,
    output logic       memBridge_load,
    output logic       memBridge_direction,
    input  logic       carry_in,
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    input  logic [1:0] carry_select,
    output logic [7:0] result,
    output logic       carry_out,
    output logic [7:0] main_bus_out,
    output logic       main_bus_oe
);

    // -------------------------------------------------------------------------
    // Reset conditioner
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync_reg;

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign reset_out_n = rst_sync_reg[1];

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    // The codes are expanded to one-hot vectors. Each strobe then picks its own
    // bit. Unused codes (main 0/8-15, load 6, side-bus 0/3) have no consumer,
    // so they decode to "no strobe".
    logic [15:0] main_assert_hot;
    logic [15:0] main_load_hot;
    logic [3:0]  lhs_hot;
    logic [3:0]  rhs_hot;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_main_hot
            assign main_assert_hot[gi] = (main_assert == 4'(gi));
            assign main_load_hot[gi]   = (main_load == 4'(gi));
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_side_hot
            assign lhs_hot[gi] = (lhs_assert == 2'(gi));
            assign rhs_hot[gi] = (rhs_assert == 2'(gi));
        end
    endgenerate

    // Strobe vector layout, shared by the next-state and output mapping.
    localparam int S_A_LOAD     = 0;
    localparam int S_A_ASSERT   = 1;
    localparam int S_A_LHS      = 2;
    localparam int S_A_RHS      = 3;
    localparam int S_B_LOAD     = 4;
    localparam int S_B_ASSERT   = 5;
    localparam int S_B_LHS      = 6;
    localparam int S_B_RHS      = 7;
    localparam int S_C_LOAD     = 8;
    localparam int S_C_ASSERT   = 9;
    localparam int S_TL_LOAD    = 10;
    localparam int S_TL_ASSERT  = 11;
    localparam int S_TH_LOAD    = 12;
    localparam int S_TH_ASSERT  = 13;
    localparam int S_ALU_ASSERT = 14;
    localparam int S_MEM_LOAD   = 15;
    localparam int S_MEM_DIR    = 16;
    localparam int S_W          = 17;

    logic [S_W-1:0] strobe_next;
    logic [S_W-1:0] strobe_reg;

    always_comb begin
        strobe_next               = '0;
        strobe_next[S_A_ASSERT]   = main_assert_hot[1];
        strobe_next[S_B_ASSERT]   = main_assert_hot[2];
        strobe_next[S_C_ASSERT]   = main_assert_hot[3];
        strobe_next[S_TL_ASSERT]  = main_assert_hot[4];
        strobe_next[S_TH_ASSERT]  = main_assert_hot[5];
        strobe_next[S_ALU_ASSERT] = main_assert_hot[6];
        strobe_next[S_A_LOAD]     = main_load_hot[1];
        strobe_next[S_B_LOAD]     = main_load_hot[2];
        strobe_next[S_C_LOAD]     = main_load_hot[3];
        strobe_next[S_TL_LOAD]    = main_load_hot[4];
        strobe_next[S_TH_LOAD]    = main_load_hot[5];
        strobe_next[S_A_LHS]      = lhs_hot[1];
        strobe_next[S_B_LHS]      = lhs_hot[2];
        strobe_next[S_A_RHS]      = rhs_hot[1];
        strobe_next[S_B_RHS]      = rhs_hot[2];
        // When both codes are 7, the memory-read direction wins.
        strobe_next[S_MEM_LOAD]   = main_assert_hot[7] | main_load_hot[7];
        strobe_next[S_MEM_DIR]    = main_assert_hot[7];
    end

    // The strobes clear immediately when the external reset is asserted.
    // They stay cleared until the conditioned reset has been seen high at a
    // clock edge. The first real decode is therefore on the edge after
    // reset_out_n rises.
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            strobe_reg <= '0;
        end else if (!reset_out_n) begin
            strobe_reg <= '0;
        end else begin
            strobe_reg <= strobe_next;
        end
    end

    assign reg_A_load          = strobe_reg[S_A_LOAD];
    assign reg_A_assert        = strobe_reg[S_A_ASSERT];
    assign reg_A_LHS           = strobe_reg[S_A_LHS];
    assign reg_A_RHS           = strobe_reg[S_A_RHS];
    assign reg_B_load          = strobe_reg[S_B_LOAD];
    assign reg_B_assert        = strobe_reg[S_B_ASSERT];
    assign reg_B_LHS           = strobe_reg[S_B_LHS];
    assign reg_B_RHS           = strobe_reg[S_B_RHS];
    assign reg_Const_load      = strobe_reg[S_C_LOAD];
    assign reg_Const_assert    = strobe_reg[S_C_ASSERT];
    assign reg_TL_load         = strobe_reg[S_TL_LOAD];
    assign reg_TL_assert       = strobe_reg[S_TL_ASSERT];
    assign reg_TH_load         = strobe_reg[S_TH_LOAD];
    assign reg_TH_assert       = strobe_reg[S_TH_ASSERT];
    assign alu_assert          = strobe_reg[S_ALU_ASSERT];
    assign memBridge_load      = strobe_reg[S_MEM_LOAD];
    assign memBridge_direction = strobe_reg[S_MEM_DIR];

    // -------------------------------------------------------------------------
    // ALU adder
    // -------------------------------------------------------------------------
    logic       carry_term;
    logic [8:0] sum_wide;

    always_comb begin
        carry_term = 1'b0;
        case (carry_select)
            2'd1:    carry_term = 1'b1;
            2'd2:    carry_term = carry_in;
            default: carry_term = 1'b0;
        endcase
    end

    assign sum_wide  = {1'b0, lhs} + {1'b0, rhs} + {8'd0, carry_term};
    assign result    = sum_wide[7:0];
    assign carry_out = sum_wide[8];

    // The ALU output is zeroed when it is not selected. This keeps the bus
    // value clean even where the mux downstream ignores main_bus_oe.
    assign main_bus_out = alu_assert ? result : 8'h00;
    assign main_bus_oe  = alu_assert;

endmodule

// File: tb/tb_bus_alu_ctrl.sv
module tb_bus_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset_in_n;
    logic       reset_out_n;
    logic [3:0] main_assert;
    logic [3:0] main_load;
    logic [1:0] lhs_assert;
    logic [1:0] rhs_assert;
    logic       reg_A_load, reg_A_assert, reg_A_LHS, reg_A_RHS;
    logic       reg_B_load, reg_B_assert, reg_B_LHS, reg_B_RHS;
    logic       reg_Const_load, reg_Const_assert;
    logic       reg_TL_load, reg_TL_assert, reg_TH_load, reg_TH_assert;
    logic       alu_assert, memBridge_load, memBridge_direction;
    logic       carry_in;
    logic [7:0] lhs, rhs;
    logic [1:0] carry_select;
    logic [7:0] result;
    logic       carry_out;
    logic [7:0] main_bus_out;
    logic       main_bus_oe;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_alu_ctrl dut (
        .clk                 (clk),
        .reset_in_n          (reset_in_n),
        .reset_out_n         (reset_out_n),
        .main_assert         (main_assert),
        .main_load           (main_load),
        .lhs_assert          (lhs_assert),
        .rhs_assert          (rhs_assert),
        .reg_A_load          (reg_A_load),
        .reg_A_assert        (reg_A_assert),
        .reg_A_LHS           (reg_A_LHS),
        .reg_A_RHS           (reg_A_RHS),
        .reg_B_load          (reg_B_load),
        .reg_B_assert        (reg_B_assert),
        .reg_B_LHS           (reg_B_LHS),
        .reg_B_RHS           (reg_B_RHS),
        .reg_Const_load      (reg_Const_load),
        .reg_Const_assert    (reg_Const_assert),
        .reg_TL_load         (reg_TL_load),
        .reg_TL_assert       (reg_TL_assert),
        .reg_TH_load         (reg_TH_load),
        .reg_TH_assert       (reg_TH_assert),
        .alu_assert          (alu_assert),
        .memBridge_load      (memBridge_load),
        .memBridge_direction (memBridge_direction),
        .carry_in            (carry_in),
        .lhs                 (lhs),
        .rhs                 (rhs),
        .carry_select        (carry_select),
        .result              (result),
        .carry_out           (carry_out),
        .main_bus_out        (main_bus_out),
        .main_bus_oe         (main_bus_oe)
    );

    // The observed strobes are packed into one vector for compact comparison.
    // main_bus_oe is included so that its gating is checked on every
    // transaction.
    localparam logic [17:0] A_LOAD  = 18'h1 << 0;
    localparam logic [17:0] A_ASRT  = 18'h1 << 1;
    localparam logic [17:0] A_LHS   = 18'h1 << 2;
    localparam logic [17:0] A_RHS   = 18'h1 << 3;
    localparam logic [17:0] B_LOAD  = 18'h1 << 4;
    localparam logic [17:0] B_ASRT  = 18'h1 << 5;
    localparam logic [17:0] B_LHS   = 18'h1 << 6;
    localparam logic [17:0] B_RHS   = 18'h1 << 7;
    localparam logic [17:0] C_LOAD  = 18'h1 << 8;
    localparam logic [17:0] C_ASRT  = 18'h1 << 9;
    localparam logic [17:0] TL_LOAD = 18'h1 << 10;
    localparam logic [17:0] TL_ASRT = 18'h1 << 11;
    localparam logic [17:0] TH_LOAD = 18'h1 << 12;
    localparam logic [17:0] TH_ASRT = 18'h1 << 13;
    localparam logic [17:0] ALU     = 18'h1 << 14;
    localparam logic [17:0] M_LOAD  = 18'h1 << 15;
    localparam logic [17:0] M_DIR   = 18'h1 << 16;
    localparam logic [17:0] OE      = 18'h1 << 17;

    logic [17:0] obs;
    assign obs = {main_bus_oe, memBridge_direction, memBridge_load, alu_assert,
                  reg_TH_assert, reg_TH_load, reg_TL_assert, reg_TL_load,
                  reg_Const_assert, reg_Const_load,
                  reg_B_RHS, reg_B_LHS, reg_B_assert, reg_B_load,
                  reg_A_RHS, reg_A_LHS, reg_A_assert, reg_A_load};

    // Applies the codes and advances one clock. Outputs are sampled 1 time
    // unit after the edge.
    task automatic drive(input logic [3:0] ma, input logic [3:0] ml,
                         input logic [1:0] la, input logic [1:0] ra);
        main_assert = ma;
        main_load   = ml;
        lhs_assert  = la;
        rhs_assert  = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_in_n = 1'b0;
        drive(4'd1, 4'd0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (reset_out_n !== 1'b0 || obs !== 18'h0 || main_bus_out !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d rst_out=%b strobes=%h bus=%h, need 0/0/00",
                         i, reset_out_n, obs, main_bus_out);
            end
            @(posedge clk); #1;
        end
        reset_in_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (reset_out_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_edge1 rst_out=%b need 0", reset_out_n);
        end
        @(posedge clk); #1;
        tests_run++;
        if (reset_out_n !== 1'b1 || obs !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_edge2 rst_out=%b strobes=%h need 1/0", reset_out_n, obs);
        end
        @(posedge clk); #1;
        tests_run++;
        if (obs !== A_ASRT) begin
            tests_failed++;
            $display("FAIL first_decode strobes=%h need %h", obs, A_ASRT);
        end
        $display("[TB] reset sequence done, rst_out=%b strobes=%h", reset_out_n, obs);

        // A reset pulse between edges must clear the strobes with no edge.
        #3 reset_in_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 18'h0 || reset_out_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_clear strobes=%h rst_out=%b need 0/0", obs, reset_out_n);
        end
        #1 reset_in_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (reset_out_n !== 1'b1 || obs !== 18'h0) begin
            tests_failed++;
            $display("FAIL rerelease rst_out=%b strobes=%h need 1/0", reset_out_n, obs);
        end
        $display("[TB] async reset pulse checked");
    endtask

    task automatic test_bus_decode();
        lhs = 8'h12; rhs = 8'h34; carry_select = 2'd0;
        drive(4'd1, 4'd2, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (A_ASRT | B_LOAD)) begin
            tests_failed++;
            $display("FAIL decode_A_B strobes=%h need %h", obs, A_ASRT | B_LOAD);
        end
        $display("[TB] ma=1 ml=2 -> strobes=%h", obs);
        drive(4'd6, 4'd3, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (ALU | C_LOAD | OE) || main_bus_out !== 8'h46) begin
            tests_failed++;
            $display("FAIL decode_alu_const strobes=%h bus=%h need %h/46",
                     obs, main_bus_out, ALU | C_LOAD | OE);
        end
        $display("[TB] ma=6 ml=3 -> strobes=%h bus=%h", obs, main_bus_out);
        drive(4'd5, 4'd4, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (TH_ASRT | TL_LOAD)) begin
            tests_failed++;
            $display("FAIL decode_TH_TL strobes=%h need %h", obs, TH_ASRT | TL_LOAD);
        end
        drive(4'd4, 4'd5, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (TL_ASRT | TH_LOAD)) begin
            tests_failed++;
            $display("FAIL decode_TL_TH strobes=%h need %h", obs, TL_ASRT | TH_LOAD);
        end
        drive(4'd3, 4'd1, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (C_ASRT | A_LOAD)) begin
            tests_failed++;
            $display("FAIL decode_C_A strobes=%h need %h", obs, C_ASRT | A_LOAD);
        end
        // The same register may be both asserted and loaded.
        drive(4'd2, 4'd2, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (B_ASRT | B_LOAD)) begin
            tests_failed++;
            $display("FAIL decode_same_reg strobes=%h need %h", obs, B_ASRT | B_LOAD);
        end
        // Code 0 and codes 8-15, plus load code 6, decode to no strobe.
        drive(4'd0, 4'd6, 2'd0, 2'd0);
        tests_run++;
        if (obs !== 18'h0) begin
            tests_failed++;
            $display("FAIL decode_none0 strobes=%h need 0", obs);
        end
        for (int c = 8; c < 16; c++) begin
            drive(4'(c), 4'(c), 2'd0, 2'd0);
            tests_run++;
            if (obs !== 18'h0) begin
                tests_failed++;
                $display("FAIL decode_none code=%0d strobes=%h need 0", c, obs);
            end
            $display("[TB] code %0d -> strobes=%h", c, obs);
        end
    endtask

    task automatic test_mem_bridge();
        drive(4'd7, 4'd0, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (M_LOAD | M_DIR)) begin
            tests_failed++;
            $display("FAIL mem_read strobes=%h need %h", obs, M_LOAD | M_DIR);
        end
        drive(4'd0, 4'd7, 2'd0, 2'd0);
        tests_run++;
        if (obs !== M_LOAD) begin
            tests_failed++;
            $display("FAIL mem_write strobes=%h need %h", obs, M_LOAD);
        end
        drive(4'd7, 4'd7, 2'd0, 2'd0);
        tests_run++;
        if (obs !== (M_LOAD | M_DIR)) begin
            tests_failed++;
            $display("FAIL mem_both strobes=%h need %h", obs, M_LOAD | M_DIR);
        end
        $display("[TB] memory bridge both=7 -> strobes=%h", obs);
    endtask

    task automatic test_lhs_rhs();
        drive(4'd0, 4'd0, 2'd2, 2'd1);
        tests_run++;
        if (obs !== (B_LHS | A_RHS)) begin
            tests_failed++;
            $display("FAIL side_B_A strobes=%h need %h", obs, B_LHS | A_RHS);
        end
        drive(4'd0, 4'd0, 2'd1, 2'd2);
        tests_run++;
        if (obs !== (A_LHS | B_RHS)) begin
            tests_failed++;
            $display("FAIL side_A_B strobes=%h need %h", obs, A_LHS | B_RHS);
        end
        drive(4'd0, 4'd0, 2'd3, 2'd1);
        tests_run++;
        if (obs !== A_RHS) begin
            tests_failed++;
            $display("FAIL side_lhs3 strobes=%h need %h", obs, A_RHS);
        end
        drive(4'd0, 4'd0, 2'd2, 2'd3);
        tests_run++;
        if (obs !== B_LHS) begin
            tests_failed++;
            $display("FAIL side_rhs3 strobes=%h need %h", obs, B_LHS);
        end
        $display("[TB] lhs/rhs decode done, strobes=%h", obs);
    endtask

    task automatic test_adder();
        logic [7:0] l_v [6]  = '{8'hFF, 8'h10, 8'h10, 8'h10, 8'h10, 8'h80};
        logic [7:0] r_v [6]  = '{8'h01, 8'h20, 8'h20, 8'h20, 8'h20, 8'h7F};
        logic [1:0] s_v [6]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        logic       ci_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] res_v [6] = '{8'h00, 8'h31, 8'h31, 8'h30, 8'h30, 8'h00};
        logic       co_v [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            lhs = l_v[i]; rhs = r_v[i]; carry_select = s_v[i]; carry_in = ci_v[i];
            #1;
            tests_run++;
            if (result !== res_v[i] || carry_out !== co_v[i]) begin
                tests_failed++;
                $display("FAIL adder_%0d got %b_%h need %b_%h", i, carry_out, result, co_v[i], res_v[i]);
            end
            $display("[TB] add %h+%h sel=%0d ci=%b -> %b_%h", l_v[i], r_v[i], s_v[i], ci_v[i], carry_out, result);
        end
    endtask

    task automatic test_bus_gating();
        lhs = 8'h7F; rhs = 8'h01; carry_select = 2'd0;
        drive(4'd1, 4'd0, 2'd0, 2'd0);
        tests_run++;
        if (main_bus_out !== 8'h00 || main_bus_oe !== 1'b0 || result !== 8'h80) begin
            tests_failed++;
            $display("FAIL gate_off bus=%h oe=%b res=%h need 00/0/80", main_bus_out, main_bus_oe, result);
        end
        drive(4'd6, 4'd0, 2'd0, 2'd0);
        tests_run++;
        if (main_bus_out !== 8'h80 || main_bus_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL gate_on bus=%h oe=%b need 80/1", main_bus_out, main_bus_oe);
        end
        $display("[TB] gating: alu on -> bus=%h oe=%b", main_bus_out, main_bus_oe);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ma_v [5] = '{4'd2, 4'd7, 4'd6, 4'd0, 4'd1};
        logic [3:0]  ml_v [5] = '{4'd1, 4'd3, 4'd7, 4'd5, 4'd1};
        logic [1:0]  la_v [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [1:0]  ra_v [5] = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
        logic [17:0] ex_v [5];
        ex_v[0] = B_ASRT | A_LOAD | A_LHS | B_RHS;
        ex_v[1] = M_LOAD | M_DIR | C_LOAD | A_RHS;
        ex_v[2] = ALU | OE | M_LOAD | B_LHS;
        ex_v[3] = TH_LOAD | B_RHS;
        ex_v[4] = A_ASRT | A_LOAD | A_LHS | A_RHS;
        for (int i = 0; i < 5; i++) begin
            drive(ma_v[i], ml_v[i], la_v[i], ra_v[i]);
            tests_run++;
            if (obs !== ex_v[i]) begin
                tests_failed++;
                $display("FAIL b2b_%0d strobes=%h need %h", i, obs, ex_v[i]);
            end
            $display("[TB] b2b %0d ma=%0d ml=%0d la=%0d ra=%0d -> %h", i, ma_v[i], ml_v[i], la_v[i], ra_v[i], obs);
        end
    endtask

    initial begin
        reset_in_n   = 1'b0;
        main_assert  = 4'd0;
        main_load    = 4'd0;
        lhs_assert   = 2'd0;
        rhs_assert   = 2'd0;
        carry_in     = 1'b0;
        lhs          = 8'h00;
        rhs          = 8'h00;
        carry_select = 2'd0;
        test_reset();
        test_bus_decode();
        test_mem_bridge();
        test_lhs_rhs();
        test_adder();
        test_bus_gating();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
